// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - result source ports, rollback and register-file write port
interface writeback_arbiter_if;
    logic         ix_valid;
    logic         ix_ready;
    logic [1:0]   ix_thread_idx;
    logic         ix_vector;
    logic [4:0]   ix_reg;
    logic [511:0] ix_value;
    logic [15:0]  ix_mask;

    logic         fx_valid;
    logic         fx_ready;
    logic [1:0]   fx_thread_idx;
    logic         fx_vector;
    logic [4:0]   fx_reg;
    logic [511:0] fx_value;
    logic [15:0]  fx_mask;

    logic         dd_valid;
    logic         dd_ready;
    logic [1:0]   dd_thread_idx;
    logic         dd_vector;
    logic [4:0]   dd_reg;
    logic [511:0] dd_value;
    logic [15:0]  dd_mask;

    logic         rollback_en;
    logic [1:0]   rollback_thread_idx;

    logic         wb_writeback_en;
    logic [1:0]   wb_writeback_thread_idx;
    logic         wb_writeback_vector;
    logic [511:0] wb_writeback_value;
    logic [15:0]  wb_writeback_mask;
    logic [4:0]   wb_writeback_reg;

    modport master (
        output ix_valid, ix_thread_idx, ix_vector, ix_reg, ix_value, ix_mask,
        output fx_valid, fx_thread_idx, fx_vector, fx_reg, fx_value, fx_mask,
        output dd_valid, dd_thread_idx, dd_vector, dd_reg, dd_value, dd_mask,
        output rollback_en, rollback_thread_idx,
        input  ix_ready, fx_ready, dd_ready,
        input  wb_writeback_en, wb_writeback_thread_idx, wb_writeback_vector,
        input  wb_writeback_value, wb_writeback_mask, wb_writeback_reg
    );

    modport slave (
        input  ix_valid, ix_thread_idx, ix_vector, ix_reg, ix_value, ix_mask,
        input  fx_valid, fx_thread_idx, fx_vector, fx_reg, fx_value, fx_mask,
        input  dd_valid, dd_thread_idx, dd_vector, dd_reg, dd_value, dd_mask,
        input  rollback_en, rollback_thread_idx,
        output ix_ready, fx_ready, dd_ready,
        output wb_writeback_en, wb_writeback_thread_idx, wb_writeback_vector,
        output wb_writeback_value, wb_writeback_mask, wb_writeback_reg
    );
endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - per-source result queues with round-robin register-file writeback
module writeback_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input logic               clk,
    input logic               reset,
    writeback_arbiter_if.slave bus
);
    localparam int NSRC = 3;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;

    // Source index 0 = ix, 1 = fx, 2 = dd
    logic [NSRC-1:0] src_valid;
    logic [NSRC-1:0] src_vector;
    logic [1:0]      src_thread [NSRC];
    logic [4:0]      src_reg    [NSRC];
    logic [511:0]    src_value  [NSRC];
    logic [15:0]     src_mask   [NSRC];

    assign src_valid  = {bus.dd_valid, bus.fx_valid, bus.ix_valid};
    assign src_vector = {bus.dd_vector, bus.fx_vector, bus.ix_vector};
    assign src_thread[0] = bus.ix_thread_idx;
    assign src_thread[1] = bus.fx_thread_idx;
    assign src_thread[2] = bus.dd_thread_idx;
    assign src_reg[0]    = bus.ix_reg;
    assign src_reg[1]    = bus.fx_reg;
    assign src_reg[2]    = bus.dd_reg;
    assign src_value[0]  = bus.ix_value;
    assign src_value[1]  = bus.fx_value;
    assign src_value[2]  = bus.dd_value;
    assign src_mask[0]   = bus.ix_mask;
    assign src_mask[1]   = bus.fx_mask;
    assign src_mask[2]   = bus.dd_mask;

    // Queue storage; only squash bits and pointers need reset
    logic [1:0]            ent_thread_q [NSRC][FIFO_DEPTH];
    logic                  ent_vector_q [NSRC][FIFO_DEPTH];
    logic [4:0]            ent_reg_q    [NSRC][FIFO_DEPTH];
    logic [511:0]          ent_value_q  [NSRC][FIFO_DEPTH];
    logic [15:0]           ent_mask_q   [NSRC][FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] ent_squash_q [NSRC];
    logic [PW-1:0]         head_q       [NSRC];
    logic [PW-1:0]         tail_q       [NSRC];
    logic [CW-1:0]         count_q      [NSRC];
    logic [1:0]            rr_last_q;

    logic         wb_en_q;
    logic [1:0]   wb_thread_q;
    logic         wb_vector_q;
    logic [4:0]   wb_reg_q;
    logic [511:0] wb_value_q;
    logic [15:0]  wb_mask_q;

    logic [NSRC-1:0] src_ready;
    logic [NSRC-1:0] push;
    logic [NSRC-1:0] head_squash;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] drop;
    logic [NSRC-1:0] grant;
    logic [NSRC-1:0] pop;
    logic            grant_any;
    logic [1:0]      grant_idx;

    // Ready from registered occupancy; a head squashed now (bit set or same-cycle rollback) is dropped, not granted
    always_comb begin
        src_ready   = '0;
        push        = '0;
        head_squash = '0;
        eligible    = '0;
        drop        = '0;
        for (int s = 0; s < NSRC; s++) begin
            src_ready[s]   = count_q[s] < CW'(FIFO_DEPTH);
            push[s]        = src_valid[s] && src_ready[s] &&
                             !(bus.rollback_en && src_thread[s] == bus.rollback_thread_idx);
            head_squash[s] = ent_squash_q[s][head_q[s]] ||
                             (bus.rollback_en && ent_thread_q[s][head_q[s]] == bus.rollback_thread_idx);
            eligible[s]    = (count_q[s] != '0) && !head_squash[s];
            drop[s]        = (count_q[s] != '0) && head_squash[s];
        end
    end

    // Round-robin search starting at the source after the last one granted
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = 2'd0;
        for (int k = 1; k <= NSRC; k++) begin
            logic [1:0] c;
            c = 2'((int'(rr_last_q) + k) % NSRC);
            if (!grant_any && eligible[c]) begin
                grant_any = 1'b1;
                grant_idx = c;
                grant[c]  = 1'b1;
            end
        end
    end

    assign pop = drop | grant;

    // Queue pointers, occupancy, squash bits, arbitration pointer and write enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NSRC; s++) begin
                count_q[s]      <= '0;
                head_q[s]       <= '0;
                tail_q[s]       <= '0;
                ent_squash_q[s] <= '0;
            end
            rr_last_q <= 2'd2;
            wb_en_q   <= 1'b0;
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                for (int e = 0; e < FIFO_DEPTH; e++) begin
                    if (bus.rollback_en && ent_thread_q[s][e] == bus.rollback_thread_idx)
                        ent_squash_q[s][e] <= 1'b1;
                end
                if (push[s]) begin
                    ent_squash_q[s][tail_q[s]] <= 1'b0;
                    tail_q[s] <= tail_q[s] + PW'(1);
                end
                if (pop[s])
                    head_q[s] <= head_q[s] + PW'(1);
                count_q[s] <= count_q[s] + CW'(push[s]) - CW'(pop[s]);
            end
            wb_en_q <= grant_any;
            if (grant_any)
                rr_last_q <= grant_idx;
        end
    end

    // Entry payload capture and write-port field register
    always_ff @(posedge clk) begin
        for (int s = 0; s < NSRC; s++) begin
            if (push[s]) begin
                ent_thread_q[s][tail_q[s]] <= src_thread[s];
                ent_vector_q[s][tail_q[s]] <= src_vector[s];
                ent_reg_q[s][tail_q[s]]    <= src_reg[s];
                ent_value_q[s][tail_q[s]]  <= src_value[s];
                ent_mask_q[s][tail_q[s]]   <= src_mask[s];
            end
        end
        if (grant_any) begin
            wb_thread_q <= ent_thread_q[grant_idx][head_q[grant_idx]];
            wb_vector_q <= ent_vector_q[grant_idx][head_q[grant_idx]];
            wb_reg_q    <= ent_reg_q[grant_idx][head_q[grant_idx]];
            wb_value_q  <= ent_value_q[grant_idx][head_q[grant_idx]];
            wb_mask_q   <= ent_mask_q[grant_idx][head_q[grant_idx]];
        end
    end

    // A sender must not present a result while its queue is full
    always_ff @(posedge clk) begin
        for (int s = 0; s < NSRC; s++) begin
            if (!reset)
                assert (!(src_valid[s] && !src_ready[s]));
        end
    end

    assign bus.ix_ready                = src_ready[0];
    assign bus.fx_ready                = src_ready[1];
    assign bus.dd_ready                = src_ready[2];
    assign bus.wb_writeback_en         = wb_en_q;
    assign bus.wb_writeback_thread_idx = wb_thread_q;
    assign bus.wb_writeback_vector     = wb_vector_q;
    assign bus.wb_writeback_reg        = wb_reg_q;
    assign bus.wb_writeback_value      = wb_value_q;
    assign bus.wb_writeback_mask       = wb_mask_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - self-checking bench for writeback_arbiter
module tb_writeback_arbiter;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [1:0]   thr;
        logic         vec;
        logic [4:0]   rg;
        logic [511:0] val;
        logic [15:0]  msk;
        logic         sq;
    } ent_t;

    typedef struct {
        int         cyc;
        logic [1:0] thr;
        logic [4:0] rg;
    } log_t;

    logic clk;
    logic reset;
    writeback_arbiter_if bus();

    writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid  [3];
    logic [1:0]   in_thr    [3];
    logic         in_vec    [3];
    logic [4:0]   in_rg     [3];
    logic [511:0] in_val    [3];
    logic [15:0]  in_msk    [3];
    logic         in_rb_en;
    logic [1:0]   in_rb_thr;
    logic         src_ready [3];

    assign bus.ix_valid = in_valid[0];
    assign bus.ix_thread_idx = in_thr[0];
    assign bus.ix_vector = in_vec[0];
    assign bus.ix_reg = in_rg[0];
    assign bus.ix_value = in_val[0];
    assign bus.ix_mask = in_msk[0];
    assign bus.fx_valid = in_valid[1];
    assign bus.fx_thread_idx = in_thr[1];
    assign bus.fx_vector = in_vec[1];
    assign bus.fx_reg = in_rg[1];
    assign bus.fx_value = in_val[1];
    assign bus.fx_mask = in_msk[1];
    assign bus.dd_valid = in_valid[2];
    assign bus.dd_thread_idx = in_thr[2];
    assign bus.dd_vector = in_vec[2];
    assign bus.dd_reg = in_rg[2];
    assign bus.dd_value = in_val[2];
    assign bus.dd_mask = in_msk[2];
    assign bus.rollback_en = in_rb_en;
    assign bus.rollback_thread_idx = in_rb_thr;
    assign src_ready[0] = bus.ix_ready;
    assign src_ready[1] = bus.fx_ready;
    assign src_ready[2] = bus.dd_ready;

    int   checks;
    int   failures;
    int   cyc;
    int   valid_pct;
    int   last_src;
    ent_t mq   [3][$];
    ent_t stim [3][$];
    log_t wlog [$];

    function automatic ent_t mk(logic [1:0] thr, logic vec, logic [4:0] rg, logic [511:0] val, logic [15:0] msk);
        ent_t e;
        e.thr = thr; e.vec = vec; e.rg = rg; e.val = val; e.msk = msk; e.sq = 1'b0;
        return e;
    endfunction

    function automatic logic [511:0] rand_val();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock: present stimulus, advance the queue model, check the write port one edge later
    task automatic cycle();
        int   g;
        ent_t ge;
        ent_t e;
        bit   mrdy [3];
        logic exp_en;
        g  = -1;
        ge = '0;
        for (int s = 0; s < 3; s++) begin
            mrdy[s] = (mq[s].size() < DEPTH);
            checks++;
            if (src_ready[s] !== mrdy[s]) begin
                failures++;
                $display("FAIL ready_src%0d cyc=%0d got=%0b exp=%0b", s, cyc, src_ready[s], mrdy[s]);
            end
            if (stim[s].size() > 0 && mrdy[s] && src_ready[s] === 1'b1 && $urandom_range(99) < valid_pct) begin
                e = stim[s][0];
                in_valid[s] = 1'b1;
                in_thr[s] = e.thr; in_vec[s] = e.vec; in_rg[s] = e.rg; in_val[s] = e.val; in_msk[s] = e.msk;
            end else begin
                in_valid[s] = 1'b0;
            end
        end
        if (in_rb_en) begin
            for (int s = 0; s < 3; s++)
                for (int i = 0; i < mq[s].size(); i++)
                    if (mq[s][i].thr == in_rb_thr) begin
                        e = mq[s][i]; e.sq = 1'b1; mq[s][i] = e;
                    end
        end
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (last_src + k) % 3;
            if (g < 0 && mq[c].size() > 0 && !mq[c][0].sq) g = c;
        end
        for (int s = 0; s < 3; s++) begin
            if (mq[s].size() > 0 && (mq[s][0].sq || s == g)) begin
                if (s == g) ge = mq[s][0];
                void'(mq[s].pop_front());
            end
        end
        for (int s = 0; s < 3; s++) begin
            if (in_valid[s]) begin
                e = stim[s].pop_front();
                if (!(in_rb_en && e.thr == in_rb_thr)) mq[s].push_back(e);
            end
        end
        if (g >= 0) last_src = g;
        exp_en = (g >= 0);
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if (bus.wb_writeback_en !== exp_en) begin
            failures++;
            $display("FAIL wb_en cyc=%0d got=%0b exp=%0b", cyc, bus.wb_writeback_en, exp_en);
        end
        if (exp_en && bus.wb_writeback_en === 1'b1) begin
            checks++;
            if ({bus.wb_writeback_thread_idx, bus.wb_writeback_vector, bus.wb_writeback_reg, bus.wb_writeback_mask}
                !== {ge.thr, ge.vec, ge.rg, ge.msk}) begin
                failures++;
                $display("FAIL wb_fields cyc=%0d got thr=%0d vec=%0b reg=%0d mask=%h exp thr=%0d vec=%0b reg=%0d mask=%h",
                         cyc, bus.wb_writeback_thread_idx, bus.wb_writeback_vector, bus.wb_writeback_reg,
                         bus.wb_writeback_mask, ge.thr, ge.vec, ge.rg, ge.msk);
            end
            checks++;
            if (bus.wb_writeback_value !== ge.val) begin
                failures++;
                $display("FAIL wb_value cyc=%0d got=%h exp=%h", cyc, bus.wb_writeback_value, ge.val);
            end
        end
        if (bus.wb_writeback_en === 1'b1)
            wlog.push_back('{cyc, bus.wb_writeback_thread_idx, bus.wb_writeback_reg});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((stim[0].size() + stim[1].size() + stim[2].size() +
                mq[0].size() + mq[1].size() + mq[2].size()) > 0 && n < 300) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL drain_timeout got=%0d cycles exp<300", n);
        end
        cycle();
        cycle();
    endtask

    task automatic apply_reset();
        #1;
        reset = 1'b1;
        in_rb_en = 1'b0;
        for (int s = 0; s < 3; s++) in_valid[s] = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (src_ready[s] !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready_src%0d got=%0b exp=1", s, src_ready[s]);
            end
        end
        checks++;
        if (bus.wb_writeback_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_wb_en got=%0b exp=0", bus.wb_writeback_en);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            mq[s].delete();
            stim[s].delete();
        end
        last_src = 2;
        wlog.delete();
        cyc = 0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.wb_writeback_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_cycle got=%0b exp=0", bus.wb_writeback_en);
        end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        stim[0].push_back(mk(2'd1, 1'b0, 5'd5, 512'h1234, 16'h8000));
        cycle();
        checks++;
        if (bus.wb_writeback_en !== 1'b0) begin
            failures++;
            $display("FAIL single_c1_en got=%0b exp=0", bus.wb_writeback_en);
        end
        cycle();
        checks++;
        if ({bus.wb_writeback_en, bus.wb_writeback_thread_idx, bus.wb_writeback_vector, bus.wb_writeback_reg}
            !== {1'b1, 2'd1, 1'b0, 5'd5} || bus.wb_writeback_value[31:0] !== 32'h1234) begin
            failures++;
            $display("FAIL single_c2 got en=%0b thr=%0d vec=%0b reg=%0d lane0=%h exp en=1 thr=1 vec=0 reg=5 lane0=1234",
                     bus.wb_writeback_en, bus.wb_writeback_thread_idx, bus.wb_writeback_vector,
                     bus.wb_writeback_reg, bus.wb_writeback_value[31:0]);
        end
        cycle();
        checks++;
        if (bus.wb_writeback_en !== 1'b0) begin
            failures++;
            $display("FAIL single_c3_en got=%0b exp=0", bus.wb_writeback_en);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        for (int t = 0; t < 2; t++)
            for (int s = 0; s < 3; s++)
                stim[s].push_back(mk(2'd0, 1'b0, 5'(s + 1), rand_val(), 16'h8000));
        drain();
        checks++;
        if (wlog.size() != 6) begin
            failures++;
            $display("FAIL contention_count got=%0d exp=6", wlog.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wlog[i].rg !== 5'((i % 3) + 1) || wlog[i].cyc != i + 2) begin
                    failures++;
                    $display("FAIL contention_w%0d got reg=%0d cyc=%0d exp reg=%0d cyc=%0d",
                             i, wlog[i].rg, wlog[i].cyc, (i % 3) + 1, i + 2);
                end
            end
        end
    endtask

    task automatic test_full();
        int dd_regs [$];
        apply_reset();
        for (int i = 0; i < 6; i++) stim[1].push_back(mk(2'd0, 1'b0, 5'(10 + i), rand_val(), 16'hFFFF));
        for (int i = 0; i < 3; i++) stim[2].push_back(mk(2'd1, 1'b0, 5'(20 + i), rand_val(), 16'h8000));
        cycle();
        cycle();
        checks++;
        if (src_ready[2] !== 1'b0) begin
            failures++;
            $display("FAIL full_dd_ready got=%0b exp=0", src_ready[2]);
        end
        drain();
        foreach (wlog[i]) if (wlog[i].rg >= 5'd20) dd_regs.push_back(int'(wlog[i].rg));
        checks++;
        if (dd_regs.size() != 3 || dd_regs[0] != 20 || dd_regs[1] != 21 || dd_regs[2] != 22) begin
            failures++;
            $display("FAIL full_dd_order got count=%0d exp 3 in order 20,21,22", dd_regs.size());
        end
    endtask

    task automatic test_rollback();
        apply_reset();
        stim[0].push_back(mk(2'd2, 1'b0, 5'd7, rand_val(), 16'h8000));
        stim[1].push_back(mk(2'd3, 1'b0, 5'd8, rand_val(), 16'h8000));
        cycle();
        in_rb_en = 1'b1;
        in_rb_thr = 2'd2;
        stim[2].push_back(mk(2'd2, 1'b0, 5'd9, rand_val(), 16'h8000));
        cycle();
        in_rb_en = 1'b0;
        drain();
        checks++;
        if (wlog.size() != 1) begin
            failures++;
            $display("FAIL rollback_count got=%0d exp=1", wlog.size());
        end else begin
            checks++;
            if (wlog[0].rg !== 5'd8 || wlog[0].thr !== 2'd3) begin
                failures++;
                $display("FAIL rollback_entry got reg=%0d thr=%0d exp reg=8 thr=3", wlog[0].rg, wlog[0].thr);
            end
        end
    endtask

    task automatic test_vector();
        logic [511:0] v;
        apply_reset();
        v = rand_val();
        stim[1].push_back(mk(2'd0, 1'b1, 5'd4, v, 16'hF0F0));
        cycle();
        cycle();
        checks++;
        if ({bus.wb_writeback_en, bus.wb_writeback_vector, bus.wb_writeback_reg, bus.wb_writeback_mask}
            !== {1'b1, 1'b1, 5'd4, 16'hF0F0} || bus.wb_writeback_value !== v) begin
            failures++;
            $display("FAIL vector got en=%0b vec=%0b reg=%0d mask=%h exp en=1 vec=1 reg=4 mask=f0f0",
                     bus.wb_writeback_en, bus.wb_writeback_vector, bus.wb_writeback_reg, bus.wb_writeback_mask);
        end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        stim[0].push_back(mk(2'd0, 1'b0, 5'd11, rand_val(), 16'h8000));
        stim[1].push_back(mk(2'd1, 1'b0, 5'd12, rand_val(), 16'h8000));
        cycle();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (bus.wb_writeback_en !== 1'b0 || {src_ready[0], src_ready[1], src_ready[2]} !== 3'b111) begin
                failures++;
                $display("FAIL midflight_c%0d got en=%0b ready=%b%b%b exp en=0 ready=111",
                         i, bus.wb_writeback_en, src_ready[0], src_ready[1], src_ready[2]);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        valid_pct = 70;
        for (int n = 0; n < 1500; n++) begin
            for (int s = 0; s < 3; s++)
                if (stim[s].size() < 3 && $urandom_range(99) < 60)
                    stim[s].push_back(mk(2'($urandom_range(3)), 1'($urandom_range(1)), 5'($urandom_range(31)),
                                         rand_val(), 16'($urandom)));
            in_rb_en = ($urandom_range(15) == 0);
            in_rb_thr = 2'($urandom_range(3));
            cycle();
        end
        in_rb_en = 1'b0;
        valid_pct = 100;
        drain();
        checks++;
        if (wlog.size() < 100) begin
            failures++;
            $display("FAIL random_activity got=%0d writes exp>=100", wlog.size());
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        valid_pct = 100;
        last_src = 2;
        reset = 1'b1;
        in_rb_en = 1'b0;
        in_rb_thr = 2'd0;
        for (int s = 0; s < 3; s++) begin
            in_valid[s] = 1'b0; in_thr[s] = '0; in_vec[s] = 1'b0;
            in_rg[s] = '0; in_val[s] = '0; in_msk[s] = '0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_rollback();
        test_vector();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
